// File: rtl/word_gen_conf_tx_pkg.sv
// Shared constants for the word generator configuration byte protocol.
// The state encoding is shared with the receiving word_gen.
package word_gen_conf_tx_pkg;

  localparam logic [7:0] CONF_MAGIC = 8'hBB;

  typedef enum logic [3:0] {
    S_IDLE,
    S_NUM_RANGES,
    S_R_NUM_CHARS,
    S_R_START_IDX,
    S_R_CHARS,
    S_NUM_WORDS,
    S_INSERT_POS,
    S_GEN0,
    S_GEN1,
    S_GEN2,
    S_GEN3,
    S_MAGIC
  } state_t;

  function automatic int chars_number_max(input int char_bits);
    return (char_bits == 7) ? 96 : 224;
  endfunction

endpackage

// File: rtl/word_gen_conf_char_ram.sv
// Charset table: one write port, one synchronous read port, address = {range, char}.
module word_gen_conf_char_ram #(
  parameter int CHAR_BITS  = 7,
  parameter int RANGES_MAX = 8,
  localparam int AW        = $clog2(RANGES_MAX) + 8
) (
  input  logic                 CLK,
  input  logic                 wr_en,
  input  logic [AW-1:0]        wr_addr,
  input  logic [CHAR_BITS-1:0] wr_data,
  input  logic [AW-1:0]        rd_addr,
  output logic [CHAR_BITS-1:0] rd_data
);

  logic [CHAR_BITS-1:0] mem [RANGES_MAX*256];

  always_ff @(posedge CLK) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/word_gen_conf_tx.sv
// Serialises one word_gen configuration onto the din/wr_conf_en/conf_full byte link.
//   state         | meaning
//   S_IDLE        | waiting for start, tables writable
//   S_NUM_RANGES  | range count byte
//   S_R_NUM_CHARS | per range: char count
//   S_R_START_IDX | per range: start index
//   S_R_CHARS     | per range: charset bytes, one per cycle
//   S_NUM_WORDS   | inserted word count (0/1)
//   S_INSERT_POS  | insert position, only when a word is inserted
//   S_GEN0..3     | generation limit, LSB first
//   S_MAGIC       | trailer 0xBB
module word_gen_conf_tx
  import word_gen_conf_tx_pkg::*;
#(
  parameter int CHAR_BITS         = 7,
  parameter int RANGES_MAX        = 8,
  parameter int WORD_MAX_LEN      = RANGES_MAX,
  localparam int CHARS_NUMBER_MAX = chars_number_max(CHAR_BITS),
  localparam int RI_W             = $clog2(RANGES_MAX)
) (
  input  logic                 CLK,
  input  logic                 RST_N,
  input  logic                 desc_wr_en,
  input  logic [RI_W-1:0]      desc_idx,
  input  logic [7:0]           desc_num_chars,
  input  logic [7:0]           desc_start_idx,
  input  logic                 char_wr_en,
  input  logic [RI_W-1:0]      char_range,
  input  logic [7:0]           char_addr,
  input  logic [CHAR_BITS-1:0] char_din,
  input  logic                 start,
  input  logic [7:0]           num_ranges,
  input  logic [7:0]           num_words,
  input  logic [7:0]           insert_pos,
  input  logic [31:0]          num_generate,
  input  logic [15:0]          inpkt_id,
  output logic [7:0]           dout,
  output logic                 wr_conf_en,
  input  logic                 conf_full,
  output logic [15:0]          pkt_id,
  output logic                 busy,
  output logic                 done,
  output logic                 err
);

  localparam int RC_W              = $clog2(RANGES_MAX + 1);
  localparam logic [7:0] CHARS_MAX = 8'(CHARS_NUMBER_MAX);
  localparam logic [7:0] RANGES_M8 = 8'(RANGES_MAX);
  localparam logic [7:0] WORD_M8   = 8'(WORD_MAX_LEN);

  state_t state, state_nxt;
  logic [RC_W-1:0] rng_cnt, rng_nxt, nr_r;
  logic [7:0] chr_cnt, chr_nxt;
  logic nw_r;
  logic [7:0] ins_r;
  logic [31:0] ngen_r;
  logic [7:0] desc_nc [RANGES_MAX];
  logic [7:0] desc_si [RANGES_MAX];
  logic [CHAR_BITS-1:0] ram_q;
  logic [RI_W-1:0] rng_idx;
  logic last_rng, last_chr, range_end, desc_bad, start_bad, start_ok;

  assign rng_idx    = rng_cnt[RI_W-1:0];
  assign busy       = (state != S_IDLE);
  assign wr_conf_en = busy & ~conf_full;
  assign last_rng   = (rng_cnt == nr_r - RC_W'(1));
  assign last_chr   = (chr_cnt == desc_nc[rng_idx] - 8'd1);
  assign desc_bad   = (desc_num_chars == 8'd0) || (desc_num_chars > CHARS_MAX) ||
                      (desc_start_idx >= desc_num_chars);
  assign start_bad  = (num_ranges > RANGES_M8) || (num_words > 8'd1) ||
                      ((num_ranges == 8'd0) && (num_words == 8'd0)) ||
                      ((num_words == 8'd1) && (insert_pos > WORD_M8));
  assign start_ok   = start & ~busy & ~err;

  // Read address follows the next-cycle counters so the char is ready when its state arrives.
  word_gen_conf_char_ram #(.CHAR_BITS(CHAR_BITS), .RANGES_MAX(RANGES_MAX)) u_char_ram (
    .CLK     (CLK),
    .wr_en   (char_wr_en & ~busy),
    .wr_addr ({char_range, char_addr}),
    .wr_data (char_din),
    .rd_addr ({rng_nxt[RI_W-1:0], chr_nxt}),
    .rd_data (ram_q)
  );

  always_comb begin
    state_nxt = state;
    rng_nxt   = rng_cnt;
    chr_nxt   = chr_cnt;
    range_end = 1'b0;
    dout      = 8'h00;
    unique case (state)
      S_IDLE: if (start_ok && !start_bad) begin
        state_nxt = S_NUM_RANGES;
        rng_nxt   = '0;
        chr_nxt   = '0;
      end
      S_NUM_RANGES: begin
        dout = 8'(nr_r);
        if (wr_conf_en) state_nxt = (nr_r == '0) ? S_NUM_WORDS : S_R_NUM_CHARS;
      end
      S_R_NUM_CHARS: begin
        dout = desc_nc[rng_idx];
        if (wr_conf_en) state_nxt = S_R_START_IDX;
      end
      S_R_START_IDX: begin
        dout = desc_si[rng_idx];
        if (wr_conf_en) begin
          if (desc_nc[rng_idx] == 8'd0) range_end = 1'b1;
          else begin
            state_nxt = S_R_CHARS;
            chr_nxt   = '0;
          end
        end
      end
      S_R_CHARS: begin
        dout = 8'(ram_q);
        if (wr_conf_en) begin
          if (last_chr) range_end = 1'b1;
          else chr_nxt = chr_cnt + 8'd1;
        end
      end
      S_NUM_WORDS: begin
        dout = {7'd0, nw_r};
        if (wr_conf_en) state_nxt = nw_r ? S_INSERT_POS : S_GEN0;
      end
      S_INSERT_POS: begin
        dout = ins_r;
        if (wr_conf_en) state_nxt = S_GEN0;
      end
      S_GEN0: begin
        dout = ngen_r[7:0];
        if (wr_conf_en) state_nxt = S_GEN1;
      end
      S_GEN1: begin
        dout = ngen_r[15:8];
        if (wr_conf_en) state_nxt = S_GEN2;
      end
      S_GEN2: begin
        dout = ngen_r[23:16];
        if (wr_conf_en) state_nxt = S_GEN3;
      end
      S_GEN3: begin
        dout = ngen_r[31:24];
        if (wr_conf_en) state_nxt = S_MAGIC;
      end
      S_MAGIC: begin
        dout = CONF_MAGIC;
        if (wr_conf_en) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
    if (range_end) begin
      if (last_rng) state_nxt = S_NUM_WORDS;
      else begin
        state_nxt = S_R_NUM_CHARS;
        rng_nxt   = rng_cnt + RC_W'(1);
      end
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state   <= S_IDLE;
      rng_cnt <= '0;
      chr_cnt <= '0;
      nr_r    <= '0;
      nw_r    <= 1'b0;
      ins_r   <= '0;
      ngen_r  <= '0;
      pkt_id  <= '0;
      done    <= 1'b0;
      err     <= 1'b0;
      for (int i = 0; i < RANGES_MAX; i++) begin
        desc_nc[i] <= '0;
        desc_si[i] <= '0;
      end
    end else begin
      state   <= state_nxt;
      rng_cnt <= rng_nxt;
      chr_cnt <= chr_nxt;
      done    <= (state == S_MAGIC) && wr_conf_en;
      if (desc_wr_en && !busy) begin
        if (desc_bad) err <= 1'b1;
        else begin
          desc_nc[desc_idx] <= desc_num_chars;
          desc_si[desc_idx] <= desc_start_idx;
        end
      end
      if (start_ok) begin
        if (start_bad) err <= 1'b1;
        else begin
          nr_r   <= num_ranges[RC_W-1:0];
          nw_r   <= num_words[0];
          ins_r  <= insert_pos;
          ngen_r <= num_generate;
          pkt_id <= inpkt_id;
        end
      end
    end
  end

endmodule

// File: tb/tb_word_gen_conf_tx.sv
// Scoreboard bench for word_gen_conf_tx: expected bytes queued at start, popped on each transfer.
module tb_word_gen_conf_tx;

  logic        CLK, RST_N;
  logic        desc_wr_en;
  logic [2:0]  desc_idx;
  logic [7:0]  desc_num_chars, desc_start_idx;
  logic        char_wr_en;
  logic [2:0]  char_range;
  logic [7:0]  char_addr;
  logic [6:0]  char_din;
  logic        start;
  logic [7:0]  num_ranges, num_words, insert_pos;
  logic [31:0] num_generate;
  logic [15:0] inpkt_id;
  logic [7:0]  dout;
  logic        wr_conf_en, conf_full;
  logic [15:0] pkt_id;
  logic        busy, done, err;

  int n_tests = 0;
  int n_fail  = 0;
  logic rand_full = 1'b0;
  logic [7:0] exp_q [$];
  int cyc;

  localparam logic [7:0] PKT1 [16] = '{8'h02, 8'h03, 8'h00, 8'h61, 8'h62, 8'h63, 8'h02, 8'h01,
                                       8'h30, 8'h31, 8'h00, 8'h05, 8'h00, 8'h00, 8'h00, 8'hBB};
  localparam logic [7:0] PKT2 [8]  = '{8'h00, 8'h01, 8'h03, 8'h00, 8'h00, 8'h00, 8'h00, 8'hBB};
  localparam logic [7:0] PKT0 [9]  = '{8'h01, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'hBB};

  word_gen_conf_tx dut (
    .CLK(CLK), .RST_N(RST_N),
    .desc_wr_en(desc_wr_en), .desc_idx(desc_idx),
    .desc_num_chars(desc_num_chars), .desc_start_idx(desc_start_idx),
    .char_wr_en(char_wr_en), .char_range(char_range), .char_addr(char_addr), .char_din(char_din),
    .start(start), .num_ranges(num_ranges), .num_words(num_words), .insert_pos(insert_pos),
    .num_generate(num_generate), .inpkt_id(inpkt_id),
    .dout(dout), .wr_conf_en(wr_conf_en), .conf_full(conf_full),
    .pkt_id(pkt_id), .busy(busy), .done(done), .err(err)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  initial begin
    conf_full = 1'b0;
    forever begin
      @(posedge CLK); #1;
      conf_full = rand_full ? 1'($urandom_range(0, 1)) : 1'b0;
    end
  end

  // Every transferred byte must match the queue head; while stalled, dout must already show it.
  initial forever begin
    @(negedge CLK);
    if (RST_N && wr_conf_en) begin
      if (exp_q.size() == 0) chk("sb_empty", exp_q.size(), 1);
      else chk("byte", dout, exp_q.pop_front());
    end else if (RST_N && busy && conf_full && exp_q.size() != 0) begin
      chk("hold", dout, exp_q[0]);
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic write_desc(input int idx, input int nc, input int si);
    @(posedge CLK); #1;
    desc_wr_en = 1'b1; desc_idx = 3'(idx);
    desc_num_chars = 8'(nc); desc_start_idx = 8'(si);
    @(posedge CLK); #1;
    desc_wr_en = 1'b0;
  endtask

  task automatic write_char(input int r, input int a, input int c);
    @(posedge CLK); #1;
    char_wr_en = 1'b1; char_range = 3'(r); char_addr = 8'(a); char_din = 7'(c);
    @(posedge CLK); #1;
    char_wr_en = 1'b0;
  endtask

  task automatic load_cfg();
    write_desc(0, 3, 0);
    write_desc(1, 2, 1);
    write_char(0, 0, 8'h61);
    write_char(0, 1, 8'h62);
    write_char(0, 2, 8'h63);
    write_char(1, 0, 8'h30);
    write_char(1, 1, 8'h31);
  endtask

  task automatic pulse_start(input int nr, input int nw, input int ip, input int ng, input int id);
    @(posedge CLK); #1;
    start = 1'b1; num_ranges = 8'(nr); num_words = 8'(nw); insert_pos = 8'(ip);
    num_generate = 32'(ng); inpkt_id = 16'(id);
    @(posedge CLK); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int limit, output int cycles);
    cycles = 0;
    while (!done && cycles < limit) begin
      @(negedge CLK);
      cycles++;
    end
  endtask

  task automatic push_pkt1();
    for (int i = 0; i < 16; i++) exp_q.push_back(PKT1[i]);
  endtask

  task automatic apply_reset();
    RST_N = 1'b0;
    repeat (2) @(posedge CLK);
    #3 RST_N = 1'b1;
  endtask

  initial begin
    RST_N = 1'b0; desc_wr_en = 0; desc_idx = 0; desc_num_chars = 0; desc_start_idx = 0;
    char_wr_en = 0; char_range = 0; char_addr = 0; char_din = 0; start = 0;
    num_ranges = 0; num_words = 0; insert_pos = 0; num_generate = 0; inpkt_id = 0;
    repeat (2) @(posedge CLK);
    #3 RST_N = 1'b1;
    @(negedge CLK);
    chk("rst_dout", dout, 0);
    chk("rst_wr_en", wr_conf_en, 0);
    chk("rst_pkt_id", pkt_id, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);

    load_cfg();
    push_pkt1();
    pulse_start(2, 0, 0, 5, 16'h1234);
    wait_done(200, cyc);
    chk("p1_cycles", cyc, 17);
    chk("p1_busy_at_done", busy, 0);
    chk("p1_pkt_id", pkt_id, 16'h1234);
    chk("p1_sb_left", exp_q.size(), 0);
    @(negedge CLK);
    chk("p1_done_pulse", done, 0);

    for (int i = 0; i < 8; i++) exp_q.push_back(PKT2[i]);
    pulse_start(0, 1, 3, 0, 16'h0042);
    wait_done(200, cyc);
    chk("p2_cycles", cyc, 9);
    chk("p2_sb_left", exp_q.size(), 0);

    rand_full = 1'b1;
    push_pkt1();
    pulse_start(2, 0, 0, 5, 16'h0777);
    wait_done(2000, cyc);
    rand_full = 1'b0;
    chk("full_done", done, 1);
    chk("full_cycles_ge", cyc >= 17, 1);
    chk("full_sb_left", exp_q.size(), 0);

    // Table writes while a packet is in flight must not land.
    push_pkt1();
    pulse_start(2, 0, 0, 5, 16'h0001);
    write_desc(0, 5, 1);
    write_char(0, 0, 8'h7A);
    wait_done(200, cyc);
    chk("drop_done", done, 1);
    push_pkt1();
    pulse_start(2, 0, 0, 5, 16'h0002);
    wait_done(200, cyc);
    chk("drop_cycles", cyc, 17);
    chk("drop_sb_left", exp_q.size(), 0);

    push_pkt1();
    pulse_start(2, 0, 0, 5, 16'h0003);
    repeat (4) @(negedge CLK);
    #2 RST_N = 1'b0;
    #1;
    chk("midrst_wr_en", wr_conf_en, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_dout", dout, 0);
    chk("midrst_q_left", exp_q.size(), 12);
    exp_q.delete();
    @(posedge CLK);
    #3 RST_N = 1'b1;

    for (int i = 0; i < 9; i++) exp_q.push_back(PKT0[i]);
    pulse_start(1, 0, 0, 0, 16'h0004);
    wait_done(200, cyc);
    chk("blank_desc_cycles", cyc, 10);
    chk("blank_sb_left", exp_q.size(), 0);

    load_cfg();
    push_pkt1();
    pulse_start(2, 0, 0, 5, 16'h0005);
    wait_done(200, cyc);
    chk("post_rst_cycles", cyc, 17);
    chk("post_rst_sb_left", exp_q.size(), 0);

    write_desc(2, 3, 3);
    @(negedge CLK);
    chk("bad_desc_err", err, 1);
    pulse_start(2, 0, 0, 5, 16'h0006);
    repeat (5) @(negedge CLK);
    chk("bad_desc_start_ign", busy, 0);
    apply_reset();
    @(negedge CLK);
    chk("err_cleared", err, 0);

    load_cfg();
    pulse_start(1, 2, 0, 0, 16'h0007);
    repeat (3) @(negedge CLK);
    chk("nw2_err", err, 1);
    chk("nw2_busy", busy, 0);
    pulse_start(2, 0, 0, 5, 16'h0008);
    repeat (5) @(negedge CLK);
    chk("nw2_start_ign", busy, 0);
    chk("nw2_pkt_id", pkt_id, 0);
    apply_reset();

    pulse_start(9, 0, 0, 0, 16'h0009);
    repeat (3) @(negedge CLK);
    chk("nr9_err", err, 1);
    chk("nr9_busy", busy, 0);
    apply_reset();
    @(negedge CLK);
    chk("final_err", err, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
